// File: rtl/fetch_stage.sv
// Instruction fetch stage for a simple multi-cycle RISC-V core.
// Alternates between requesting an instruction from memory and holding it
// for the decoder, then picks the next fetch address from the branch/jump
// outcome once the downstream stage consumes the held instruction.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rstN,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemAck,
    input  logic [31:0] imemData,
    input  logic        stall,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    input  logic [31:0] pcTarget,
    output logic [31:0] instr,
    output logic [6:0]  op,
    output logic [31:0] pc,
    output logic [31:0] pcPlus4,
    output logic        instrValid,
    output logic        misalign
);

    typedef enum logic {
        REQ,
        HOLD
    } stateT;

    stateT       state;
    stateT       stateNext;
    logic [31:0] pcF;
    logic [31:0] instrReg;
    logic [31:0] pcReg;
    logic [31:0] pcPlus4Reg;
    logic        misalignReg;
    logic        capture;
    logic        advance;
    logic        pcSrc;
    logic [31:0] nextPc;

    // Redirect decision; a misaligned target has its low two bits dropped.
    assign pcSrc  = (branch & zero) | jump;
    assign nextPc = pcSrc ? {pcTarget[31:2], 2'b00} : pcPlus4Reg;

    // State register; reset always restarts in the fetching state.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state <= REQ;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and handshake outputs for the fetch/hold sequence.
    always_comb begin
        stateNext  = state;
        imemReq    = 1'b0;
        instrValid = 1'b0;
        capture    = 1'b0;
        advance    = 1'b0;
        case (state)
            REQ: begin
                imemReq = 1'b1;
                if (imemAck) begin
                    capture   = 1'b1;
                    stateNext = HOLD;
                end
            end
            HOLD: begin
                instrValid = 1'b1;
                if (!stall) begin
                    advance   = 1'b1;
                    stateNext = REQ;
                end
            end
        endcase
    end

    // Captures returned instructions and steps the fetch PC on each advance.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            pcF         <= RESET_PC;
            instrReg    <= NOP_INSTR;
            pcReg       <= RESET_PC;
            pcPlus4Reg  <= RESET_PC + 32'd4;
            misalignReg <= 1'b0;
        end else begin
            misalignReg <= 1'b0;
            if (capture) begin
                instrReg   <= imemData;
                pcReg      <= pcF;
                pcPlus4Reg <= pcF + 32'd4;
            end
            if (advance) begin
                pcF         <= nextPc;
                misalignReg <= pcSrc && (pcTarget[1:0] != 2'b00);
            end
        end
    end

    assign imemAddr = pcF;
    assign instr    = instrValid ? instrReg : NOP_INSTR;
    assign op       = instr[6:0];
    assign pc       = pcReg;
    assign pcPlus4  = pcPlus4Reg;
    assign misalign = misalignReg;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by a
// randomized phase, all compared against a behavioural model of the stage.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk;
    logic        rstN;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemData;
    logic        stall;
    logic        branch;
    logic        jump;
    logic        zero;
    logic [31:0] pcTarget;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic        instrValid;
    logic        misalign;

    int checks;
    int failures;

    // Behavioural model: whether a fetch is outstanding, where it goes,
    // and what instruction/address is being presented.
    bit          mFetching;
    logic [31:0] mFetchAddr;
    logic [31:0] mHeldInstr;
    logic [31:0] mHeldPc;
    bit          mMisalign;

    fetch_stage #(
        .RESET_PC (RESET_PC),
        .NOP_INSTR(NOP_INSTR)
    ) dut (
        .clk       (clk),
        .rstN      (rstN),
        .imemReq   (imemReq),
        .imemAddr  (imemAddr),
        .imemAck   (imemAck),
        .imemData  (imemData),
        .stall     (stall),
        .branch    (branch),
        .jump      (jump),
        .zero      (zero),
        .pcTarget  (pcTarget),
        .instr     (instr),
        .op        (op),
        .pc        (pc),
        .pcPlus4   (pcPlus4),
        .instrValid(instrValid),
        .misalign  (misalign)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Compares every visible output against what the model says should be seen.
    task automatic checkOutput();
        logic [31:0] expInstr;
        expInstr = mFetching ? NOP_INSTR : mHeldInstr;
        check("imemReq", {31'd0, imemReq}, {31'd0, mFetching});
        if (mFetching) check("imemAddr", imemAddr, mFetchAddr);
        check("instrValid", {31'd0, instrValid}, {31'd0, !mFetching});
        check("instr", instr, expInstr);
        check("op", {25'd0, op}, {25'd0, expInstr[6:0]});
        check("pc", pc, mHeldPc);
        check("pcPlus4", pcPlus4, mHeldPc + 32'd4);
        check("misalign", {31'd0, misalign}, {31'd0, mMisalign});
    endtask

    // Advances the model by one clock edge using the inputs present at that edge.
    task automatic modelEdge();
        logic taken;
        if (!rstN) begin
            mFetching  = 1'b1;
            mFetchAddr = RESET_PC;
            mHeldInstr = NOP_INSTR;
            mHeldPc    = RESET_PC;
            mMisalign  = 1'b0;
        end else if (mFetching) begin
            mMisalign = 1'b0;
            if (imemAck) begin
                mHeldInstr = imemData;
                mHeldPc    = mFetchAddr;
                mFetching  = 1'b0;
            end
        end else begin
            mMisalign = 1'b0;
            if (!stall) begin
                taken      = (branch && zero) || jump;
                mFetchAddr = taken ? (pcTarget & 32'hFFFF_FFFC) : mHeldPc + 32'd4;
                mMisalign  = taken && (pcTarget % 4 != 0);
                mFetching  = 1'b1;
            end
        end
    endtask

    // Drives one cycle of inputs, checks current outputs, then clocks.
    task automatic applyStimulus(input logic r, input logic a, input logic [31:0] d,
                                 input logic s, input logic b, input logic j,
                                 input logic z, input logic [31:0] t);
        rstN     = r;
        imemAck  = a;
        imemData = d;
        stall    = s;
        branch   = b;
        jump     = j;
        zero     = z;
        pcTarget = t;
        checkOutput();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic fetch(input logic [31:0] d);
        applyStimulus(1'b1, 1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic go(input logic b, input logic j, input logic z, input logic [31:0] t);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, b, j, z, t);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rstN     = 1'b0;
        imemAck  = 1'b1;
        imemData = 32'h0050_0093;
        stall    = 1'b0;
        branch   = 1'b0;
        jump     = 1'b0;
        zero     = 1'b0;
        pcTarget = 32'h0;

        // Reset with a coincident ack that must be discarded.
        @(posedge clk);
        modelEdge();
        #1;
        applyStimulus(1'b0, 1'b1, 32'h0050_0093, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("rst_addr", imemAddr, RESET_PC);
        check("rst_instr", instr, NOP_INSTR);
        check("rst_pcPlus4", pcPlus4, RESET_PC + 32'd4);
        check("rst_valid", {31'd0, instrValid}, 32'd0);

        // Sequential fetch 0x0, 0x4, 0x8, 0xC, 0x10.
        fetch(32'h0010_0093);
        check("seq_valid", {31'd0, instrValid}, 32'd1);
        check("seq_instr0", instr, 32'h0010_0093);
        go(1'b0, 1'b0, 1'b0, 32'h0);
        check("seq_addr4", imemAddr, 32'h4);
        fetch(32'h0020_0113);
        go(1'b0, 1'b0, 1'b0, 32'h0);
        check("seq_addr8", imemAddr, 32'h8);
        fetch(32'h0030_0193);
        go(1'b0, 1'b0, 1'b0, 32'h0);
        fetch(32'h0040_0213);
        go(1'b0, 1'b0, 1'b0, 32'h0);
        fetch(32'h0000_0063);
        check("br_heldPc", pc, 32'h10);

        // Taken branch, then the same branch not taken.
        go(1'b1, 1'b0, 1'b1, 32'h40);
        check("br_taken", imemAddr, 32'h40);
        fetch(32'h0000_006F);
        go(1'b0, 1'b1, 1'b0, 32'h10);
        fetch(32'h0000_0063);
        go(1'b1, 1'b0, 1'b0, 32'h40);
        check("br_nottaken", imemAddr, 32'h14);

        // Stall in HOLD with redirect inputs waving about.
        fetch(32'h00A0_0513);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, $urandom, 1'b1, 1'b1, 1'b1, 1'b1, 32'h800);
            check("stall_pc", pc, 32'h14);
            check("stall_req", {31'd0, imemReq}, 32'd0);
        end
        go(1'b0, 1'b0, 1'b0, 32'h0);
        check("stall_release", imemAddr, 32'h18);

        // Slow memory: four cycles without ack.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, $urandom, 1'b0, 1'b1, 1'b1, 1'b1, 32'h900);
            check("slow_addr", imemAddr, 32'h18);
            check("slow_op", {25'd0, op}, 32'd19);
        end
        fetch(32'h0000_006F);

        // Misaligned jal target.
        go(1'b0, 1'b1, 1'b0, 32'h102);
        check("mis_addr", imemAddr, 32'h100);
        check("mis_pulse", {31'd0, misalign}, 32'd1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("mis_clear", {31'd0, misalign}, 32'd0);

        // PC wraparound at the top of the address space.
        fetch(32'h0000_006F);
        go(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC);
        fetch(32'h0000_0013);
        check("wrap_pcPlus4", pcPlus4, 32'h0);

        // Reset while holding: no redirect applied.
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h200);
        check("rstHold_addr", imemAddr, RESET_PC);
        check("rstHold_valid", {31'd0, instrValid}, 32'd0);

        // Reset coincident with an ack mid-operation.
        fetch(32'h0000_0013);
        go(1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h0050_0093, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("rstAck_instr", instr, NOP_INSTR);
        check("rstAck_addr", imemAddr, RESET_PC);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] tgt;
            tgt = $urandom;
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            applyStimulus(($urandom_range(0, 49) != 0), ($urandom_range(0, 2) != 0), $urandom,
                          ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                          1'($urandom), tgt);
        end
        checkOutput();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
